uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte producers on the system clock. It accepts bytes over per-requester valid/ready handshakes and presents one byte at a time to the transmitter's `data_valid`/`data_in`. It tracks the transmitter's `busy` flag to sequence start and completion, and flags a transmitter that never starts. It sits between the on-chip producers (command responder, status reporter, debug port) and the UART TX.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: byte width; must match the transmitter.
- `START_TIMEOUT`, 4096: `sys_clk` cycles allowed in START for `busy` to rise; ≥ 4 × transmitter UART clock period in `sys_clk` cycles.
- `sys_clk` in 1: system clock; the only clock.
- `sreset` in 1: reset, synchronous and active-high.
- `req_valid` in `NUM_REQ`: requester i has a byte.
- `req_data` in `NUM_REQ*DATA_WIDTH`: flattened; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` out `NUM_REQ`: one-hot or zero; byte i transfers on a rising edge where `req_valid[i] & req_ready[i]`.
- `tx_data_valid` out 1: drives the transmitter's `data_valid`.
- `tx_data` out `DATA_WIDTH`: drives the transmitter's `data_in`.
- `tx_busy` in 1: the transmitter's `busy`, which is asynchronous to `sys_clk`.
- `grant_id` out `$clog2(NUM_REQ)`: index of the requester whose byte is in flight.
- `active` out 1: high in START and WAIT_DONE.
- `timeout_err` out 1: one-cycle pulse on a start timeout.

## Operation
- `tx_busy` passes through a 2-flop synchronizer to give `busy_s`. All decisions use `busy_s`.
- FSM states are IDLE, START and WAIT_DONE.
- **IDLE**
  - If `busy_s == 0` and any `req_valid` is set, the winner is the first set bit scanning upward from `rr_ptr`, with wrap-around.
  - `req_ready` is combinational and equals the one-hot winner only in IDLE with `busy_s == 0`. Otherwise it is 0.
  - On transfer: latch the winner's byte into `tx_data` and its index into `grant_id`. Set `rr_ptr <= (winner+1) mod NUM_REQ` and go to START.
- **START**
  - `tx_data_valid = 1` and `tx_data` is held stable.
  - Timeout counter: cleared on entry to START, incremented each cycle.
  - When `busy_s == 1`: clear `tx_data_valid` and go to WAIT_DONE.
  - Otherwise, when the counter reaches `START_TIMEOUT-1`: pulse `timeout_err`, clear `tx_data_valid`, go to IDLE. The byte is dropped.
- **WAIT_DONE**
  - `tx_data_valid = 0`.
  - When `busy_s == 0`, go to IDLE.
- Requesters must hold `req_valid` and `req_data` stable until transfer. A requester with `req_valid` low is skipped with no penalty.
- Simultaneous events:
  - The busy-rise check has priority over the timeout check on the same cycle.
  - `sreset` overrides every other event.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, synchronizer flops 0, timeout counter 0. Outputs: `tx_data_valid` 0, `tx_data` 0, `grant_id` 0, `active` 0, `timeout_err` 0, `req_ready` 0 while `sreset` is high.
- Transfer at edge k → `tx_data_valid` and `tx_data` are valid from edge k (registered, visible in cycle k+1).
- `tx_busy` rise → START exit after 2–3 cycles, including synchronizer latency. `tx_data_valid` therefore falls well before the transmitter returns to IDLE, so no duplicate frame is sent.
- Minimum spacing between two grants is 2 + frame time + 2 synchronizer cycles. Back-to-back requests from one requester lose priority to any other pending requester.
- Reset mid-operation:
  - FSM returns to IDLE and `tx_data_valid` drops. The in-flight byte is not reported.
  - No grant is issued while the transmitter is still busy from before the reset, because of the `busy_s` gate.
- `rr_ptr` wraps from `NUM_REQ-1` to 0.
- The timeout counter is `$clog2(START_TIMEOUT)` bits wide and never wraps; it is cleared on entry to START.

## Structure
- `uart_pkg` holds:
  - the `arb_state_t` enum (IDLE, START, WAIT_DONE);
  - shared constants `UART_DATA_WIDTH` and `UART_NUM_REQ` for the default parameters.
- One sub-module, `sync_2ff` (1-bit, `sys_clk`, synchronous reset to 0), synchronizes `tx_busy`. It is reusable elsewhere.
- Round-robin winner selection is a function inside the arbiter, not a separate module.

## Test plan
- Single request: `req_valid[2]=1`, `req_data`=0xA5, transmitter model raises busy 10 cycles later → `req_ready[2]` for exactly one cycle; `tx_data`=0xA5 with `tx_data_valid` high until 2–3 cycles after busy rises; `grant_id`=2; `rr_ptr` becomes 3.
- All four requesters valid continuously with bytes 0x10..0x13 → frames are sent in order 0,1,2,3,0,… with no duplicate and no skip.
- Transmitter never raises busy, `START_TIMEOUT`=64 → `timeout_err` pulses once, 64 cycles after entering START; FSM returns to IDLE; the next pending requester is granted.
- `sreset` asserted during WAIT_DONE while the transmitter is still busy → all outputs return to reset values; `req_ready` stays 0 until `busy_s` falls; then normal grant.
- `rr_ptr`=3 with only `req_valid[1]` and `req_valid[3]` set → requester 3 wins and `rr_ptr` wraps to 0; next grant goes to requester 1.
- Requester drops `req_valid` before acceptance while the transmitter is busy → no transfer and no `req_ready` for that requester.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and default sizes for the UART TX arbiter
//
// Purpose : arbiter FSM state encoding and default parameter values.
// Ports   : none (package).

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_NUM_REQ    = 4;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer
//
// Purpose : bring an asynchronous level into the clk domain.
// Ports   : clk    - destination clock
//           sreset - synchronous active-high reset, clears both flops
//           d      - asynchronous input
//           q      - synchronized output

module sync_2ff (
  input  logic clk,
  input  logic sreset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (sreset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
//
// Purpose : accepts bytes from NUM_REQ producers and feeds them one at a time
//           to a UART transmitter, sequencing on the transmitter busy flag.
// Ports   : sys_clk, sreset        - clock, synchronous active-high reset
//           req_valid/req_data     - per-requester byte offer (flattened data)
//           req_ready              - one-hot accept, transfer on valid & ready
//           tx_data_valid/tx_data  - byte presented to the transmitter
//           tx_busy                - transmitter busy (asynchronous)
//           grant_id               - requester whose byte is in flight
//           active                 - high in START and WAIT_DONE
//           timeout_err            - one-cycle pulse when busy never rises

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ       = UART_NUM_REQ,
  parameter  int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter  int START_TIMEOUT = 4096,
  localparam int IW            = $clog2(NUM_REQ)
) (
  input  logic                          sys_clk,
  input  logic                          sreset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [IW-1:0]                 grant_id,
  output logic                          active,
  output logic                          timeout_err
);

  localparam int                 CNT_W   = $clog2(START_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(START_TIMEOUT - 1);
  localparam logic [IW-1:0]      LAST    = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

  arb_state_t       state, state_next;
  logic             busy_s;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    winner;
  logic [CNT_W-1:0] cnt;
  logic             grant_ok;
  logic             fire;
  logic             start_timeout;

  // First valid requester at or above ptr, wrapping around.
  function automatic logic [IW-1:0] rr_winner(input logic [NUM_REQ-1:0] v,
                                               input logic [IW-1:0]      ptr);
    logic [IW-1:0] w;
    logic [IW-1:0] cand;
    logic          found;
    w     = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && v[cand]) begin
        found = 1'b1;
        w     = cand;
      end
    end
    return w;
  endfunction

  sync_2ff u_busy_sync (
    .clk    (sys_clk),
    .sreset (sreset),
    .d      (tx_busy),
    .q      (busy_s)
  );

  always_comb begin
    winner        = rr_winner(req_valid, rr_ptr);
    // busy_s gate keeps us off a transmitter still busy from before a reset.
    grant_ok      = (state == IDLE) && !busy_s && (|req_valid) && !sreset;
    req_ready     = grant_ok ? (ONE << winner) : '0;
    fire          = |(req_valid & req_ready);
    start_timeout = 1'b0;
    state_next    = state;
    case (state)
      IDLE: begin
        if (fire) state_next = START;
      end
      START: begin
        // Busy rise wins over a timeout landing on the same cycle.
        if (busy_s) begin
          state_next = WAIT_DONE;
        end else if (cnt == CNT_MAX) begin
          start_timeout = 1'b1;
          state_next    = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!busy_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_data_valid = (state == START);
  assign active        = (state != IDLE);
  assign timeout_err   = start_timeout && !sreset;

  always_ff @(posedge sys_clk) begin
    if (sreset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      tx_data  <= '0;
      grant_id <= '0;
    end else begin
      state <= state_next;
      if (fire) begin
        tx_data  <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
        grant_id <= winner;
        rr_ptr   <= (winner == LAST) ? '0 : winner + 1'b1;
        cnt      <= '0;
      end else if (state == START && state_next == START) begin
        // Only counts while staying in START, so it stops at CNT_MAX.
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 64;

  logic              sys_clk = 1'b0;
  logic              sreset  = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data  = '0;
  logic [N-1:0]      req_ready;
  logic              tx_data_valid;
  logic [DW-1:0]     tx_data;
  logic              tx_busy = 1'b0;
  logic [1:0]        grant_id;
  logic              active;
  logic              timeout_err;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .START_TIMEOUT(TO)) dut (
    .sys_clk       (sys_clk),
    .sreset        (sreset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .grant_id      (grant_id),
    .active        (active),
    .timeout_err   (timeout_err)
  );

  // Producers, scoreboard and sent-frame log.
  logic [7:0] src_q [N][$];
  logic [7:0] exp_q [$];
  logic [7:0] sent_log [$];

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 start, 2 wait-done.
  int         m_phase = 0, m_cnt = 0, m_ptr = 0, m_gid = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_f1 = 1'b0, m_bs = 1'b0;
  int         m_timeouts = 0, dut_timeouts = 0;

  // Transmitter model.
  int tx_en = 1, tx_delay = 10, tx_len = 12, tx_wait = 0, tx_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < N; k++) begin
      if (src_q[(m_ptr + k) % N].size() > 0) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = src_q[i].size() > 0;
      req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  task automatic tick();
    int           w;
    int           fire;
    logic [N-1:0] exp_rdy;
    fire = -1;
    @(negedge sys_clk);
    w       = rr_pick();
    exp_rdy = '0;
    if (!sreset && m_phase == 0 && !m_bs && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("active", active, m_phase != 0);
    chk("tx_data_valid", tx_data_valid, m_phase == 1);
    chk("timeout_err", timeout_err, !sreset && m_phase == 1 && !m_bs && m_cnt == TO - 1);
    if (timeout_err === 1'b1) dut_timeouts++;
    if (m_phase != 0) begin
      chk("tx_data", tx_data, m_byte);
      chk("grant_id", grant_id, m_gid);
    end
    // transmitter: starts a frame tx_delay cycles after seeing data_valid
    if (tx_busy) begin
      tx_left--;
      if (tx_left <= 0) tx_busy = 1'b0;
    end else if (tx_en != 0 && tx_data_valid === 1'b1) begin
      if (tx_wait >= tx_delay) begin
        tx_busy = 1'b1;
        tx_left = tx_len;
        tx_wait = 0;
        chk("frame_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("frame_byte", tx_data, exp_q.pop_front());
        sent_log.push_back(tx_data);
      end else begin
        tx_wait++;
      end
    end else begin
      tx_wait = 0;
    end
    // model transition at the coming edge
    if (sreset) begin
      m_phase = 0; m_cnt = 0; m_ptr = 0; m_byte = 8'h00; m_gid = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (exp_rdy != 0) begin
          m_phase = 1; m_cnt = 0; m_gid = w; m_byte = src_q[w][0];
          m_ptr = (w + 1) % N;
          exp_q.push_back(m_byte);
          fire = w;
        end
        1: if (m_bs) m_phase = 2;
           else if (m_cnt == TO - 1) begin
             m_phase = 0; m_timeouts++; exp_q.delete();
           end else m_cnt++;
        default: if (!m_bs) m_phase = 0;
      endcase
    end
    if (sreset) begin
      m_bs = 1'b0; m_f1 = 1'b0;
    end else begin
      m_bs = m_f1; m_f1 = tx_busy;
    end
    @(posedge sys_clk);
    #1;
    if (fire >= 0) begin
      void'(src_q[fire].pop_front());
      drive();
    end
  endtask

  task automatic run_idle(input string tag, input int max_cycles);
    int  done;
    done = 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
          src_q[3].size() == 0 && m_phase == 0 && !tx_busy && !m_bs && !m_f1) begin
        done = 1;
        break;
      end
      tick();
    end
    chk(tag, done, 1);
  endtask

  initial begin
    int base;
    int limit;

    // reset
    drive();
    repeat (3) tick();
    sreset = 1'b0;
    tick();
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_valid", tx_data_valid, 0);

    // single request on requester 2
    tx_delay = 10; tx_len = 12;
    src_q[2].push_back(8'hA5); drive();
    run_idle("drain_single", 200);
    chk("single_byte", sent_log[$], 8'hA5);

    // requester 3 alone moves the pointer back to 0
    src_q[3].push_back(8'hC3); drive();
    run_idle("drain_c3", 200);
    chk("c3_byte", sent_log[$], 8'hC3);

    // all four continuously valid: strict 0,1,2,3 rotation
    base = sent_log.size();
    tx_delay = 3; tx_len = 8;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) src_q[i].push_back(8'h10 + 8'(i));
    drive();
    run_idle("drain_all4", 1000);
    chk("all4_count", sent_log.size() - base, 12);
    for (int k = 0; k < 12; k++)
      if (base + k < sent_log.size()) chk("all4_order", sent_log[base + k], 8'h10 + 8'(k % 4));

    // wrap: pointer at 3, requesters 1 and 3 pending
    src_q[2].push_back(8'hB2); drive();
    run_idle("drain_b2", 200);
    src_q[1].push_back(8'hB1); src_q[3].push_back(8'hB3); drive();
    run_idle("drain_wrap", 400);
    chk("wrap_first", sent_log[$-1], 8'hB3);
    chk("wrap_second", sent_log[$], 8'hB1);

    // requester 0 withdraws while the transmitter is busy
    base = sent_log.size();
    tx_len = 20;
    src_q[2].push_back(8'hD2); drive();
    limit = 0;
    while (!tx_busy && limit < 100) begin tick(); limit++; end
    chk("drop_busy_seen", tx_busy, 1);
    src_q[0].push_back(8'hD0); drive();
    repeat (3) tick();
    src_q[0].delete(); drive();
    run_idle("drain_drop", 200);
    chk("drop_count", sent_log.size() - base, 1);
    chk("drop_byte", sent_log[$], 8'hD2);

    // start timeout, then the next pending requester is served
    tx_en = 0; tx_len = 10;
    src_q[1].push_back(8'h77); src_q[2].push_back(8'h88); drive();
    limit = 0;
    while (m_timeouts == 0 && limit < 200) begin tick(); limit++; end
    tx_en = 1;
    run_idle("drain_timeout", 300);
    chk("timeout_pulses", dut_timeouts, 1);
    chk("timeout_next", sent_log[$], 8'h88);

    // reset while waiting on a long frame
    tx_len = 40;
    src_q[3].push_back(8'h3C); drive();
    limit = 0;
    while (m_phase != 2 && limit < 100) begin tick(); limit++; end
    chk("rst_in_wait", active, 1);
    sreset = 1'b1;
    repeat (2) tick();
    sreset = 1'b0;
    tick();
    chk("rst2_tx_data", tx_data, 8'h00);
    chk("rst2_grant_id", grant_id, 0);
    chk("rst2_active", active, 0);
    repeat (2) tick();
    src_q[0].push_back(8'h5A); drive();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("gated_while_busy", req_ready, 0);
    end
    run_idle("drain_rst", 300);
    chk("post_rst_byte", sent_log[$], 8'h5A);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(1, 0) == 1 && src_q[i].size() < 3)
          src_q[i].push_back(8'($urandom));
      tx_delay = $urandom_range(12, 1);
      tx_len   = $urandom_range(20, 6);
      drive();
      repeat ($urandom_range(40, 5)) tick();
    end
    run_idle("drain_random", 3000);
    chk("random_scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
